soc_system_button_pio: RTL



---
 rtl/soc_system_button_pio.sv | 126 ++++++++++++
 1 files changed

// File: rtl/soc_system_button_pio.sv
// soc_system_button_pio
// Avalon-MM input PIO for pushbuttons/switches on the lightweight HPS bridge.
// Each input bit is synchronised, debounced and edge-detected. Edges of the
// configured polarity are latched into a sticky, write-1-to-clear capture
// register. A level interrupt is raised for any unmasked captured edge.

module soc_system_button_pio #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int EDGE_TYPE       = 1,
   parameter int IDLE_LEVEL      = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   // Counter only has to reach DEBOUNCE_CYCLES-1, so clog2 bits suffice
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [WIDTH-1:0] IDLE_VEC = (IDLE_LEVEL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] stable;
   logic [CNT_W-1:0] cnt [WIDTH];
   logic [WIDTH-1:0] accept;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] cap_clr;
   logic             wr_en;
   logic             mask_wr;
   logic             unused_writedata;

   // Upper writedata bits have no destination; fold them into a sink
   assign unused_writedata = ^writedata;

   assign wr_en   = chipselect && !write_n;
   assign mask_wr = wr_en && (address == 2'd2);
   assign cap_clr = (wr_en && (address == 2'd3)) ? writedata[WIDTH-1:0] : {WIDTH{1'b0}};

   // Two-flop synchroniser; resets to the idle level so no edge follows reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= IDLE_VEC;
         sync2 <= IDLE_VEC;
      end else begin
         sync1 <= in_port;
         sync2 <= sync1;
      end
   end

   // A bit is accepted on its final mismatching cycle; the edge is judged from the old stable value
   always_comb begin
      accept   = '0;
      edge_det = '0;
      for (int i = 0; i < WIDTH; i++) begin
         accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
         case (EDGE_TYPE)
            0:       edge_det[i] = accept[i] && !stable[i];
            1:       edge_det[i] = accept[i] && stable[i];
            default: edge_det[i] = accept[i];
         endcase
      end
   end

   // Per-bit debounce: count consecutive mismatches, restart on any return to the stable level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stable <= IDLE_VEC;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (accept[i]) begin
               stable[i] <= sync2[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Interrupt mask register, only the low WIDTH bits are kept
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_mask <= '0;
      end else if (mask_wr) begin
         irq_mask <= writedata[WIDTH-1:0];
      end
   end

   // Sticky edge capture; a new edge wins over a simultaneous write-1-to-clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         edge_capture <= '0;
      end else begin
         edge_capture <= (edge_capture & ~cap_clr) | edge_det;
      end
   end

   // Zero-wait-state read mux; reads never change state
   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata = 32'(stable);
         2'd2:    readdata = 32'(irq_mask);
         2'd3:    readdata = 32'(edge_capture);
         default: readdata = '0;
      endcase
   end

   assign irq = |(edge_capture & irq_mask);

endmodule
